// File: rtl/store_merge_rmw_if.sv
// +-------------------------------------------------------------------------+
// | store_merge_rmw_if : request, store-operand and data-memory bundle        |
// |                      for store_merge_rmw                                  |
// | Revision 1.0                                                              |
// +-------------------------------------------------------------------------+
`default_nettype none

interface store_merge_rmw_if;
  logic        start;
  logic [31:0] instrucao;
  logic [2:0]  addr_lo;
  logic [63:0] Dadoreg;
  logic        mem_rd_req;
  logic [63:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_req;
  logic [63:0] mem_wr_data;
  logic        mem_wr_ack;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        illegal;

  // master: control unit plus data memory; slave: the store merge block
  modport master (
    output start, instrucao, addr_lo, Dadoreg, mem_rd_data, mem_rd_valid, mem_wr_ack,
    input  mem_rd_req, mem_wr_req, mem_wr_data, busy, done, misaligned, illegal
  );

  modport slave (
    input  start, instrucao, addr_lo, Dadoreg, mem_rd_data, mem_rd_valid, mem_wr_ack,
    output mem_rd_req, mem_wr_req, mem_wr_data, busy, done, misaligned, illegal
  );
endinterface

`default_nettype wire

// File: rtl/store_merge_rmw.sv
// +-------------------------------------------------------------------------+
// | store_merge_rmw : sizes sb/sh/sw/sd store data into a 64-bit doubleword  |
// |                   using read-modify-write for sub-doubleword stores.     |
// |                   Optional alignment check: STORE_ALIGN_CHECK_EN         |
// | Revision 1.0                                                              |
// +-------------------------------------------------------------------------+
`default_nettype none

module store_merge_rmw (
  input  wire logic           clk,
  input  wire logic           reset_n,
  store_merge_rmw_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [2:0]  r_addr;
  logic [31:0] r_data;
  logic [63:0] r_rd_data;

  logic [2:0]  w_funct3;
  logic        w_illegal;
  logic        w_misaligned;
  logic [7:0]  w_lane_en;
  logic [63:0] w_lane_data;
  logic [63:0] w_merged;
  logic        w_unused;

  assign w_funct3  = bus.instrucao[14:12];
  assign w_illegal = (bus.instrucao[6:0] != 7'b0100011) || (w_funct3 > 3'b011);
  assign w_unused  = &{1'b0, bus.instrucao[31:15], bus.instrucao[11:7]};

`ifdef STORE_ALIGN_CHECK_EN
  always_comb begin
    w_misaligned = 1'b0;
    case (w_funct3)
      3'b001:  w_misaligned = bus.addr_lo[0];
      3'b010:  w_misaligned = (bus.addr_lo[1:0] != 2'b00);
      3'b011:  w_misaligned = (bus.addr_lo != 3'b000);
      default: w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // Low offset bits below the access size drop out of the lane shifts
  always_comb begin
    w_lane_en   = 8'h00;
    w_lane_data = {2{r_data}};
    case (r_funct3)
      3'b000: begin
        w_lane_en   = 8'h01 << r_addr;
        w_lane_data = {8{r_data[7:0]}};
      end
      3'b001: begin
        w_lane_en   = 8'h03 << {r_addr[2:1], 1'b0};
        w_lane_data = {4{r_data[15:0]}};
      end
      3'b010: begin
        w_lane_en   = 8'h0F << {r_addr[2], 2'b00};
        w_lane_data = {2{r_data}};
      end
      default: w_lane_en = 8'h00;
    endcase
    w_merged = r_rd_data;
    for (int k = 0; k < 8; k++) begin
      if (w_lane_en[k]) w_merged[8*k +: 8] = w_lane_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_funct3        <= 3'b000;
      r_addr          <= 3'b000;
      r_data          <= 32'h0;
      r_rd_data       <= 64'h0;
      bus.mem_rd_req  <= 1'b0;
      bus.mem_wr_req  <= 1'b0;
      bus.mem_wr_data <= 64'h0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.misaligned  <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.done       <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_funct3 <= w_funct3;
            r_addr   <= bus.addr_lo;
            r_data   <= bus.Dadoreg[31:0];
            bus.busy <= 1'b1;
            if (w_illegal) begin
              bus.illegal <= 1'b1;
              r_state     <= S_ERR;
            end else if (w_misaligned) begin
              bus.misaligned <= 1'b1;
              r_state        <= S_ERR;
            end else if (w_funct3 == 3'b011) begin
              // sd replaces the whole doubleword, so the read is skipped
              bus.mem_wr_req  <= 1'b1;
              bus.mem_wr_data <= bus.Dadoreg;
              r_state         <= S_WRITE;
            end else begin
              bus.mem_rd_req <= 1'b1;
              r_state        <= S_READ;
            end
          end
        end
        S_READ: begin
          if (bus.mem_rd_valid) begin
            r_rd_data      <= bus.mem_rd_data;
            bus.mem_rd_req <= 1'b0;
            r_state        <= S_MERGE;
          end
        end
        S_MERGE: begin
          bus.mem_wr_data <= w_merged;
          bus.mem_wr_req  <= 1'b1;
          r_state         <= S_WRITE;
        end
        S_WRITE: begin
          if (bus.mem_wr_ack) begin
            bus.mem_wr_req <= 1'b0;
            bus.done       <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          bus.mem_rd_req <= 1'b0;
          bus.mem_wr_req <= 1'b0;
          bus.busy       <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_merge_rmw.sv
// +-------------------------------------------------------------------------+
// | tb_store_merge_rmw : randomized self-checking bench for store_merge_rmw  |
// | Revision 1.0                                                              |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_store_merge_rmw;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  store_merge_rmw_if bus();

  store_merge_rmw dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] wdata;
    int          done_at;
    int          rd_first;
    int          wr_first;
    int          rd_cyc;
    int          wr_cyc;
    int          ill_at;
    int          mis_at;
    bit          rd_gap;
    bit          wr_unstable;
    bit          busy_bad;
    bit          after_bad;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: memory as an array of bytes, the store overwrites size bytes
  // starting at the offset rounded down to the access size.
  function automatic logic [63:0] ref_merge(input logic [2:0] f3, input logic [2:0] a,
                                            input logic [63:0] d, input logic [63:0] old);
    logic [7:0]  m [8];
    logic [63:0] r;
    int          size;
    int          base;
    for (int i = 0; i < 8; i++) m[i] = old[8*i +: 8];
    size = 1 << f3;
    base = (int'(a) / size) * size;
    for (int i = 0; i < size; i++) m[base + i] = d[8*i +: 8];
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i];
    return r;
  endfunction

  function automatic bit ref_illegal(input logic [31:0] ins);
    return (ins[6:0] != 7'b0100011) || (ins[14:12] > 3'd3);
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [2:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    return (int'(a) % (1 << f3)) != 0;
`else
    return (f3 == 3'd7) && (a == 3'd7) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mk_store(input logic [2:0] f3);
    return {17'($urandom), f3, 5'($urandom), 7'b0100011};
  endfunction

  // Drives one store and acts as the data memory; records what it observes.
  task automatic run_store(input logic [31:0] ins, input logic [2:0] a, input logic [63:0] d,
                           input logic [63:0] rdval, input int rd_dly, input int ack_dly,
                           input bit restart, output obs_t o);
    bit term;
    bit rd_ended;
    o.wdata = '0; o.done_at = -1; o.rd_first = -1; o.wr_first = -1;
    o.rd_cyc = 0; o.wr_cyc = 0; o.ill_at = -1; o.mis_at = -1;
    o.rd_gap = 0; o.wr_unstable = 0; o.busy_bad = 0; o.after_bad = 0;
    term = 0;
    rd_ended = 0;
    bus.instrucao = ins; bus.addr_lo = a; bus.Dadoreg = d; bus.start = 1'b1;
    bus.mem_rd_valid = 1'b0; bus.mem_wr_ack = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.instrucao = $urandom; bus.addr_lo = 3'($urandom); bus.Dadoreg = {$urandom, $urandom};
    for (int cyc = 1; cyc <= 60 && !term; cyc++) begin
      if (bus.busy !== 1'b1) o.busy_bad = 1;
      if (bus.mem_rd_req === 1'b1) begin
        if (o.rd_first < 0) o.rd_first = cyc;
        else if (rd_ended) o.rd_gap = 1;
        bus.mem_rd_valid = (o.rd_cyc >= rd_dly);
        bus.mem_rd_data  = bus.mem_rd_valid ? rdval : {$urandom, $urandom};
        o.rd_cyc++;
      end else begin
        if (o.rd_first >= 0) rd_ended = 1;
        bus.mem_rd_valid = 1'($urandom);
        bus.mem_rd_data  = {$urandom, $urandom};
      end
      if (bus.mem_wr_req === 1'b1) begin
        if (o.wr_first < 0) begin
          o.wr_first = cyc;
          o.wdata    = bus.mem_wr_data;
        end else if (bus.mem_wr_data !== o.wdata) o.wr_unstable = 1;
        bus.mem_wr_ack = (o.wr_cyc >= ack_dly);
        o.wr_cyc++;
      end else begin
        bus.mem_wr_ack = 1'($urandom);
      end
      if (bus.done === 1'b1)       begin o.done_at = cyc; term = 1; end
      if (bus.illegal === 1'b1)    begin o.ill_at  = cyc; term = 1; end
      if (bus.misaligned === 1'b1) begin o.mis_at  = cyc; term = 1; end
      if (restart && cyc == 1) begin
        bus.instrucao = mk_store(3'd0);
        bus.start     = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_wr_ack = 1'b0;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_rd_req !== 1'b0 ||
        bus.mem_wr_req !== 1'b0 || bus.illegal !== 1'b0 || bus.misaligned !== 1'b0)
      o.after_bad = 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.instrucao = '0; bus.addr_lo = '0; bus.Dadoreg = '0;
    bus.mem_rd_data = '0; bus.mem_rd_valid = 1'b0; bus.mem_wr_ack = 1'b0;
    tick(); tick();
    vectors++; if (bus.mem_rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_rd_req got=%b exp=0", bus.mem_rd_req); end
    vectors++; if (bus.mem_wr_req !== 1'b0) begin miscompares++; $display("FAIL reset_wr_req got=%b exp=0", bus.mem_wr_req); end
    vectors++; if (bus.mem_wr_data !== 64'h0) begin miscompares++; $display("FAIL reset_wr_data got=%h exp=0", bus.mem_wr_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++; if (bus.misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned got=%b exp=0", bus.misaligned); end
    vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sb();
    obs_t o;
    run_store(mk_store(3'd0), 3'd3, 64'h0000_0000_0000_00AB, 64'h1122334455667788, 0, 0, 1'b0, o);
    vectors++; if (o.wdata !== 64'h11223344AB667788) begin miscompares++; $display("FAIL sb_data got=%h exp=11223344ab667788", o.wdata); end
    vectors++; if (o.done_at !== 4) begin miscompares++; $display("FAIL sb_done_at got=%0d exp=4", o.done_at); end
    vectors++; if (o.rd_first !== 1 || o.wr_first !== 3) begin miscompares++; $display("FAIL sb_req_timing got rd=%0d wr=%0d exp rd=1 wr=3", o.rd_first, o.wr_first); end
    vectors++; if (o.busy_bad || o.after_bad) begin miscompares++; $display("FAIL sb_busy got bad=%b/%b exp 0/0", o.busy_bad, o.after_bad); end
  endtask

  task automatic test_sh_delayed();
    obs_t o;
    run_store(mk_store(3'd1), 3'd6, 64'h0000_0000_FFFF_BEEF, 64'h0, 3, 0, 1'b0, o);
    vectors++; if (o.wdata !== 64'hBEEF000000000000) begin miscompares++; $display("FAIL sh_data got=%h exp=beef000000000000", o.wdata); end
    vectors++; if (o.done_at !== 7) begin miscompares++; $display("FAIL sh_done_at got=%0d exp=7", o.done_at); end
    vectors++; if (o.rd_cyc !== 4 || o.rd_gap) begin miscompares++; $display("FAIL sh_rd_held got cycles=%0d gap=%b exp 4/0", o.rd_cyc, o.rd_gap); end
  endtask

  task automatic test_sd_restart();
    obs_t o;
    run_store(mk_store(3'd3), 3'd0, 64'hDEADBEEFCAFEF00D, {$urandom, $urandom}, 0, 0, 1'b1, o);
    vectors++; if (o.rd_first !== -1) begin miscompares++; $display("FAIL sd_no_read got rd_first=%0d exp=-1", o.rd_first); end
    vectors++; if (o.wdata !== 64'hDEADBEEFCAFEF00D) begin miscompares++; $display("FAIL sd_data got=%h exp=deadbeefcafef00d", o.wdata); end
    vectors++; if (o.done_at !== 2 || o.wr_first !== 1) begin miscompares++; $display("FAIL sd_timing got done=%0d wr=%0d exp 2/1", o.done_at, o.wr_first); end
    vectors++; if (o.after_bad) begin miscompares++; $display("FAIL sd_restart_ignored got after_bad=1 exp=0"); end
  endtask

  task automatic test_sw_offset2();
    obs_t        o;
    logic [63:0] old;
    old = {$urandom, $urandom};
    run_store(mk_store(3'd2), 3'd2, 64'h0123_4567_89AB_CDEF, old, 0, 0, 1'b0, o);
`ifdef STORE_ALIGN_CHECK_EN
    vectors++; if (o.mis_at !== 1) begin miscompares++; $display("FAIL sw_misaligned got at=%0d exp=1", o.mis_at); end
    vectors++; if (o.rd_first !== -1 || o.wr_first !== -1 || o.done_at !== -1) begin miscompares++; $display("FAIL sw_mis_no_access got rd=%0d wr=%0d done=%0d exp all -1", o.rd_first, o.wr_first, o.done_at); end
`else
    vectors++; if (o.wdata !== {old[63:32], 32'h89ABCDEF}) begin miscompares++; $display("FAIL sw_lower_word got=%h exp=%h", o.wdata, {old[63:32], 32'h89ABCDEF}); end
    vectors++; if (o.mis_at !== -1 || o.done_at !== 4) begin miscompares++; $display("FAIL sw_no_mis got mis=%0d done=%0d exp -1/4", o.mis_at, o.done_at); end
`endif
    vectors++; if (o.busy_bad || o.after_bad) begin miscompares++; $display("FAIL sw_busy got bad=%b/%b exp 0/0", o.busy_bad, o.after_bad); end
  endtask

  task automatic test_illegal();
    obs_t o;
    run_store({17'h0, 3'd3, 5'd1, 7'b0000011}, 3'd0, {$urandom, $urandom}, 64'h0, 0, 0, 1'b0, o);
    vectors++; if (o.ill_at !== 1 || o.mis_at !== -1) begin miscompares++; $display("FAIL illegal_load got ill=%0d mis=%0d exp 1/-1", o.ill_at, o.mis_at); end
    vectors++; if (o.rd_first !== -1 || o.wr_first !== -1 || o.done_at !== -1) begin miscompares++; $display("FAIL illegal_no_access got rd=%0d wr=%0d done=%0d exp all -1", o.rd_first, o.wr_first, o.done_at); end
    vectors++; if (o.busy_bad || o.after_bad) begin miscompares++; $display("FAIL illegal_busy got bad=%b/%b exp 0/0", o.busy_bad, o.after_bad); end
    run_store(mk_store(3'd5), 3'd0, {$urandom, $urandom}, 64'h0, 0, 0, 1'b0, o);
    vectors++; if (o.ill_at !== 1 || o.wr_first !== -1) begin miscompares++; $display("FAIL illegal_funct3 got ill=%0d wr=%0d exp 1/-1", o.ill_at, o.wr_first); end
  endtask

  task automatic test_reset_midwrite();
    obs_t o;
    bus.instrucao = mk_store(3'd0); bus.addr_lo = 3'd5; bus.Dadoreg = 64'h55; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10 && bus.mem_wr_req !== 1'b1; i++) begin
      bus.mem_rd_valid = bus.mem_rd_req;
      bus.mem_rd_data  = {$urandom, $urandom};
      bus.mem_wr_ack   = 1'b0;
      tick();
    end
    bus.mem_rd_valid = 1'b0; bus.mem_wr_ack = 1'b0;
    vectors++; if (bus.mem_wr_req !== 1'b1) begin miscompares++; $display("FAIL rst_reach_write got wr_req=%b exp=1", bus.mem_wr_req); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({bus.mem_rd_req, bus.mem_wr_req, bus.busy, bus.done, bus.misaligned, bus.illegal} !== 6'b0 || bus.mem_wr_data !== 64'h0)
      begin miscompares++; $display("FAIL rst_async_clear got req=%b%b busy=%b done=%b data=%h exp all 0", bus.mem_rd_req, bus.mem_wr_req, bus.busy, bus.done, bus.mem_wr_data); end
    bus.mem_wr_ack = 1'b1;
    tick(); tick();
    vectors++; if (bus.mem_wr_req !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_held got wr_req=%b done=%b exp 0/0", bus.mem_wr_req, bus.done); end
    bus.mem_wr_ack = 1'b0;
    reset_n = 1'b1;
    tick();
    run_store(mk_store(3'd0), 3'd1, 64'h0000_0000_0000_00C3, 64'hFFEEDDCCBBAA9988, 1, 1, 1'b0, o);
    vectors++; if (o.wdata !== 64'hFFEEDDCCBBAAC388) begin miscompares++; $display("FAIL rst_after_sb got=%h exp=ffeeddccbbaac388", o.wdata); end
    vectors++; if (o.done_at !== 6) begin miscompares++; $display("FAIL rst_after_done_at got=%0d exp=6", o.done_at); end
  endtask

  // Back-to-back random stores: each start lands in the cycle after the previous completion
  task automatic test_back_to_back_random();
    obs_t        o;
    logic [31:0] ins;
    logic [2:0]  a, f3;
    logic [63:0] d, old;
    int          rdd, ackd, exp_done;
    bit          exp_ill, exp_mis;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 3));
      ins = mk_store(f3);
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
      if ($urandom_range(0, 9) == 0) ins[14:12] = 3'($urandom_range(4, 7));
      f3 = ins[14:12];
      a = 3'($urandom); d = {$urandom, $urandom}; old = {$urandom, $urandom};
      rdd = $urandom_range(0, 3); ackd = $urandom_range(0, 3);
      exp_ill = ref_illegal(ins);
      exp_mis = !exp_ill && ref_misaligned(f3, a);
      run_store(ins, a, d, old, rdd, ackd, 1'($urandom), o);
      if (exp_ill || exp_mis) begin
        vectors++; if (o.ill_at !== (exp_ill ? 1 : -1) || o.mis_at !== (exp_mis ? 1 : -1))
          begin miscompares++; $display("FAIL rnd%0d_err got ill=%0d mis=%0d exp ill=%0d mis=%0d", n, o.ill_at, o.mis_at, exp_ill, exp_mis); end
        vectors++; if (o.rd_first !== -1 || o.wr_first !== -1 || o.done_at !== -1)
          begin miscompares++; $display("FAIL rnd%0d_err_access got rd=%0d wr=%0d done=%0d exp all -1", n, o.rd_first, o.wr_first, o.done_at); end
      end else begin
        exp_done = (f3 == 3'd3) ? 2 + ackd : 4 + rdd + ackd;
        vectors++; if (o.wdata !== ref_merge(f3, a, d, old))
          begin miscompares++; $display("FAIL rnd%0d_data f3=%0d a=%0d got=%h exp=%h", n, f3, a, o.wdata, ref_merge(f3, a, d, old)); end
        vectors++; if (o.done_at !== exp_done)
          begin miscompares++; $display("FAIL rnd%0d_done_at got=%0d exp=%0d", n, o.done_at, exp_done); end
        vectors++; if (o.rd_first !== ((f3 == 3'd3) ? -1 : 1) || o.rd_gap || o.wr_unstable)
          begin miscompares++; $display("FAIL rnd%0d_handshake got rd=%0d gap=%b unstable=%b", n, o.rd_first, o.rd_gap, o.wr_unstable); end
      end
      vectors++; if (o.busy_bad || o.after_bad)
        begin miscompares++; $display("FAIL rnd%0d_busy got bad=%b/%b exp 0/0", n, o.busy_bad, o.after_bad); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sb();
    test_sh_delayed();
    test_sd_restart();
    test_sw_offset2();
    test_illegal();
    test_reset_midwrite();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/store_merge_rmw.md
# store_merge_rmw

Store-path counterpart of the load sizing logic. Takes a store instruction (sb/sh/sw/sd), the register value and the low address bits, and writes the correctly sized value into the addressed byte lanes of a 64-bit memory doubleword. Sub-doubleword stores use a read-modify-write handshake with data memory. The block sits between the datapath's store operand register and the data-memory port. It is driven by the multicycle control unit through a start/done handshake.

## Interface
Parameters:
- None; data width is fixed at 64 bits and instruction width at 32 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only while busy=0
- instrucao  in  32  store instruction; opcode [6:0], funct3 [14:12]
- addr_lo  in  3  byte offset of the store within the doubleword
- Dadoreg  in  64  rs2 value to store
- mem_rd_req  out  1  read request for the addressed doubleword
- mem_rd_data  in  64  memory read data
- mem_rd_valid  in  1  mem_rd_data valid this cycle
- mem_wr_req  out  1  write request
- mem_wr_data  out  64  merged doubleword to write
- mem_wr_ack  in  1  write accepted this cycle
- busy  out  1  high from the cycle after start until the DONE cycle inclusive
- done  out  1  one-cycle completion pulse
- misaligned  out  1  one-cycle pulse when a misaligned store is rejected
- illegal  out  1  one-cycle pulse when opcode≠7'b0100011 or funct3>3'b011

## Operation
- On an accepted start, instrucao, addr_lo and Dadoreg are captured into internal registers. Later input changes have no effect.
- Decode on the captured funct3:
  - 000 = sb: byte lane k=addr_lo; bits [8k+7:8k] ← Dadoreg[7:0].
  - 001 = sh: half lane j=addr_lo[2:1]; bits [16j+15:16j] ← Dadoreg[15:0].
  - 010 = sw: word lane w=addr_lo[2]; bits [32w+31:32w] ← Dadoreg[31:0].
  - 011 = sd: whole doubleword ← Dadoreg. No read is performed.
- Unwritten lanes keep their mem_rd_data value as sampled when mem_rd_valid is high.
- FSM states: IDLE, READ, MERGE, WRITE, DONE, ERR.
  - IDLE: on start, go to ERR if illegal or misaligned. Otherwise go to WRITE for sd, or READ for all other stores.
  - READ: mem_rd_req=1 and held until mem_rd_valid; then capture the data and go to MERGE.
  - MERGE: compute the merged doubleword into a register; go to WRITE.
  - WRITE: mem_wr_req=1 with mem_wr_data stable until mem_wr_ack; then go to DONE.
  - DONE: done=1; go to IDLE.
  - ERR: misaligned or illegal=1 for one cycle, with no memory access; go to IDLE. done is not asserted.
- start while busy=1 is ignored.
- mem_rd_valid outside READ and mem_wr_ack outside WRITE are ignored.

## Timing
- Reset value of every output is 0; reset returns the FSM to IDLE.
- Reset asserted mid-operation aborts immediately. Any pending mem_rd_req/mem_wr_req drops asynchronously, and nothing is written afterwards.
- Latency from start (cycle T) with same-cycle valid/ack:
  - sb/sh/sw: mem_rd_req at T+1, MERGE at T+2, mem_wr_req at T+3, done at T+4.
  - sd: mem_wr_req at T+1, done at T+2.
  - Each wait cycle on valid or ack adds one cycle.
- Error path: misaligned or illegal pulses at T+1; busy=1 only at T+1.
- Request outputs are registered (Moore), with no combinational path from inputs to outputs.
- A new start is accepted in the cycle after done, i.e. in IDLE.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - Misaligned means sh with addr_lo[0]=1, sw with addr_lo[1:0]≠0, or sd with addr_lo≠0.
  - A misaligned store goes to ERR and pulses misaligned.
- STORE_ALIGN_CHECK_EN undefined:
  - No alignment check; misaligned never asserts and is tied to 0.
  - Offset bits below the access size are ignored: sh uses addr_lo[2:1], sw uses addr_lo[2], sd ignores addr_lo.

## Test plan
- sb: addr_lo=3, Dadoreg=0x…00AB, mem_rd_data=0x1122334455667788 → mem_wr_data=0x11223344AB667788; done at T+4.
- sh: addr_lo=6, Dadoreg=0xFFFF_BEEF, mem_rd_data=0 → mem_wr_data=0xBEEF000000000000. mem_rd_valid delayed 3 cycles → done at T+7, with mem_rd_req held throughout.
- sd: Dadoreg=0xDEADBEEFCAFEF00D, addr_lo=0 → mem_rd_req never asserts; mem_wr_data=Dadoreg; done at T+2. A start pulsed at T+1 is ignored.
- With STORE_ALIGN_CHECK_EN: sw at addr_lo=2 → misaligned=1 at T+1; no req; done stays 0. Without the macro, the same stimulus writes to the lower word.
- Illegal: instrucao opcode 0000011 (load) → illegal pulse at T+1; no memory access.
- Reset: assert reset_n=0 during WRITE with ack withheld → all outputs 0 at once; after release, a new sb completes normally.
